// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 byte constants, decoder state encoding and event layout
package ps2_pkg;

    localparam logic [7:0] CODE_EXT    = 8'hE0;
    localparam logic [7:0] CODE_BRK    = 8'hF0;
    localparam logic [7:0] CODE_ERR0   = 8'h00;
    localparam logic [7:0] CODE_BAT    = 8'hAA;
    localparam logic [7:0] CODE_PAUSE  = 8'hE1;
    localparam logic [7:0] CODE_ACK    = 8'hFA;
    localparam logic [7:0] CODE_RESEND = 8'hFE;
    localparam logic [7:0] CODE_ERR1   = 8'hFF;
    localparam logic [7:0] CODE_LSHIFT = 8'h12;
    localparam logic [7:0] CODE_RSHIFT = 8'h59;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } ps2_state_e;

    // Bit 9 released, bit 8 extended, bits 7:0 scan code.
    typedef struct packed {
        logic       released;
        logic       extended;
        logic [7:0] code;
    } ps2_event_t;

    localparam int EV_W = 10;

    // Controller/status bytes that never form a key event and abort any prefix.
    function automatic logic is_ignored(input logic [7:0] b);
        return (b == CODE_ERR0) || (b == CODE_BAT) || (b == CODE_PAUSE) ||
               (b == CODE_ACK) || (b == CODE_RESEND) || (b == CODE_ERR1);
    endfunction

endpackage

// File: rtl/ps2_scan_decoder_if.sv
// rtl/ps2_scan_decoder_if.sv - keyboard byte handshake and decoded event stream bundle
interface ps2_scan_decoder_if;
    import ps2_pkg::*;

    logic       scan_ready;
    logic [7:0] scan_code;
    logic       read;
    logic       ev_valid;
    logic       ev_ready;
    ps2_event_t ev_data;
    logic       ovf;
    logic       ovf_clr;

    modport master (
        input  scan_ready, scan_code, ev_ready, ovf_clr,
        output read, ev_valid, ev_data, ovf
    );

    modport slave (
        output scan_ready, scan_code, ev_ready, ovf_clr,
        input  read, ev_valid, ev_data, ovf
    );

endinterface

// File: rtl/ps2_event_fifo.sv
// rtl/ps2_event_fifo.sv - power-of-two event FIFO with simultaneous push/pop when full
module ps2_event_fifo
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    localparam int AW = $clog2(FIFO_DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  ps2_event_t    wdata,
    input  logic          pop,
    output ps2_event_t    rdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    ps2_event_t    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full  = (count == CW'(FIFO_DEPTH));
    assign empty = (count == '0);

    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      count <= count + CW'(1);
            else if (do_pop && !do_push) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/ps2_scan_decoder.sv
// rtl/ps2_scan_decoder.sv - PS/2 set-2 prefix decoder feeding an event FIFO; PS2_DEC_SHIFT_EN adds shift_held
module ps2_scan_decoder
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 CLOCK_50,
    input  logic                 RST,
    ps2_scan_decoder_if.master   bus
`ifdef PS2_DEC_SHIFT_EN
    ,
    output logic                 shift_held
`endif
);

    localparam logic [1:0] S_IDLE    = ST_IDLE;
    localparam logic [1:0] S_EXT     = ST_EXT;
    localparam logic [1:0] S_BRK     = ST_BRK;
    localparam logic [1:0] S_EXT_BRK = ST_EXT_BRK;
    localparam int         CW        = $clog2(FIFO_DEPTH) + 1;

    logic          ready_q;
    logic          byte_vld;
    logic [7:0]    byte_q;
    logic [1:0]    state_q;
    logic [1:0]    state_d;
    logic          push;
    ps2_event_t    ev;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          ovf_q;

    // Edge history resets high so a level already present at release is not taken.
    always_ff @(posedge CLOCK_50 or negedge RST) begin
        if (!RST) begin
            ready_q  <= 1'b1;
            byte_vld <= 1'b0;
            byte_q   <= '0;
        end else begin
            ready_q  <= bus.scan_ready;
            byte_vld <= bus.scan_ready & ~ready_q;
            if (bus.scan_ready && !ready_q) byte_q <= bus.scan_code;
        end
    end

    assign bus.read = byte_vld;

    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        ev      = '0;
        if (byte_vld) begin
            if (is_ignored(byte_q)) begin
                state_d = S_IDLE;
            end else if (byte_q == CODE_EXT) begin
                state_d = S_EXT;
            end else if (byte_q == CODE_BRK) begin
                state_d = (state_q == S_EXT || state_q == S_EXT_BRK) ? S_EXT_BRK : S_BRK;
            end else begin
                push        = 1'b1;
                ev.released = (state_q == S_BRK) || (state_q == S_EXT_BRK);
                ev.extended = (state_q == S_EXT) || (state_q == S_EXT_BRK);
                ev.code     = byte_q;
                state_d     = S_IDLE;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RST) begin
        if (!RST) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    assign fifo_pop = bus.ev_ready & ~fifo_empty;

    ps2_event_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (CLOCK_50),
        .rst_n (RST),
        .push  (push),
        .wdata (ev),
        .pop   (fifo_pop),
        .rdata (bus.ev_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign bus.ev_valid = (fifo_count != '0);

    // A new drop outranks a clear arriving in the same cycle.
    always_ff @(posedge CLOCK_50 or negedge RST) begin
        if (!RST) begin
            ovf_q <= 1'b0;
        end else if (push && fifo_full && !fifo_pop) begin
            ovf_q <= 1'b1;
        end else if (bus.ovf_clr) begin
            ovf_q <= 1'b0;
        end
    end

    assign bus.ovf = ovf_q;

`ifdef PS2_DEC_SHIFT_EN
    logic lsh_q;
    logic rsh_q;

    // Tracks key state from the decoded event, even when the FIFO drops it.
    always_ff @(posedge CLOCK_50 or negedge RST) begin
        if (!RST) begin
            lsh_q <= 1'b0;
            rsh_q <= 1'b0;
        end else if (push && !ev.extended) begin
            if (ev.code == CODE_LSHIFT) lsh_q <= ~ev.released;
            if (ev.code == CODE_RSHIFT) rsh_q <= ~ev.released;
        end
    end

    assign shift_held = lsh_q | rsh_q;
`endif

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// tb/tb_ps2_scan_decoder.sv - directed scoreboard bench for ps2_scan_decoder
module tb_ps2_scan_decoder;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ps2_scan_decoder_if bus_if ();

`ifdef PS2_DEC_SHIFT_EN
    logic shift_held;
`endif

    ps2_scan_decoder #(
        .FIFO_DEPTH (4)
    ) dut (
        .CLOCK_50 (clk),
        .RST      (rst_n),
        .bus      (bus_if)
`ifdef PS2_DEC_SHIFT_EN
        ,
        .shift_held (shift_held)
`endif
    );

    int n_pass    = 0;
    int n_total   = 0;
    int read_cnt  = 0;
    int exp_reads = 0;
    logic [9:0] exp_q [$];
    logic [9:0] mon_exp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Consumer side: every pop is scored against the oldest expected event.
    always @(negedge clk) begin
        if (bus_if.read) read_cnt++;
        if (bus_if.ev_valid && bus_if.ev_ready) begin
            check("ev_expected_pending", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                mon_exp = exp_q.pop_front();
                check("ev_data_pop", 32'(bus_if.ev_data), 32'(mon_exp));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus_if.scan_code  = b;
        bus_if.scan_ready = 1'b1;
        exp_reads++;
        step();
        bus_if.scan_ready = 1'b0;
        step();
    endtask

    task automatic wait_drain(input string tag);
        int k = 0;
        while ((exp_q.size() != 0 || bus_if.ev_valid) && k < 40) begin
            step();
            k++;
        end
        check({tag, "_queue"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_valid"}, 32'(bus_if.ev_valid), 32'd0);
        check({tag, "_reads"}, 32'(read_cnt), 32'(exp_reads));
    endtask

    initial begin
        rst_n             = 1'b0;
        bus_if.scan_ready = 1'b1;
        bus_if.scan_code  = 8'h1C;
        bus_if.ev_ready   = 1'b0;
        bus_if.ovf_clr    = 1'b0;
        step();
        step();
        check("rst_read", 32'(bus_if.read), 32'd0);
        check("rst_ev_valid", 32'(bus_if.ev_valid), 32'd0);
        check("rst_ev_data", 32'(bus_if.ev_data), 32'd0);
        check("rst_ovf", 32'(bus_if.ovf), 32'd0);

        rst_n = 1'b1;
        repeat (3) step();
        check("level_at_release_reads", 32'(read_cnt), 32'd0);
        check("level_at_release_valid", 32'(bus_if.ev_valid), 32'd0);
        bus_if.scan_ready = 1'b0;
        step();

        // make, then break
        bus_if.ev_ready = 1'b1;
        exp_q.push_back(10'h01C);
        send_byte(8'h1C);
        exp_q.push_back(10'h21C);
        send_byte(8'hF0);
        send_byte(8'h1C);
        wait_drain("make_break");

        // extended make and extended break
        exp_q.push_back(10'h175);
        send_byte(8'hE0);
        send_byte(8'h75);
        exp_q.push_back(10'h375);
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        wait_drain("extended");

        // E0 after F0 discards the break; ignored byte aborts the E0 prefix
        exp_q.push_back(10'h175);
        send_byte(8'hF0);
        send_byte(8'hE0);
        send_byte(8'h75);
        exp_q.push_back(10'h075);
        send_byte(8'hE0);
        send_byte(8'hFA);
        send_byte(8'h75);
        wait_drain("prefix_abort");

        // BAT byte cancels break; held level gives one capture
        exp_q.push_back(10'h01C);
        send_byte(8'hF0);
        send_byte(8'hAA);
        send_byte(8'h1C);
        exp_q.push_back(10'h01C);
        bus_if.scan_code  = 8'h1C;
        bus_if.scan_ready = 1'b1;
        exp_reads++;
        repeat (20) step();
        bus_if.scan_ready = 1'b0;
        step();
        step();
        wait_drain("bat_and_hold");

        // overflow: first-event latency, then fill past depth
        bus_if.ev_ready = 1'b0;
        exp_q.push_back(10'h016);
        bus_if.scan_code  = 8'h16;
        bus_if.scan_ready = 1'b1;
        exp_reads++;
        step();
        check("lat_read_n1", 32'(bus_if.read), 32'd1);
        check("lat_valid_n1", 32'(bus_if.ev_valid), 32'd0);
        bus_if.scan_ready = 1'b0;
        step();
        check("lat_valid_n2", 32'(bus_if.ev_valid), 32'd1);
        check("lat_data_n2", 32'(bus_if.ev_data), 32'h016);
        exp_q.push_back(10'h01E);
        exp_q.push_back(10'h026);
        exp_q.push_back(10'h025);
        send_byte(8'h1E);
        send_byte(8'h26);
        send_byte(8'h25);
        check("full_no_ovf", 32'(bus_if.ovf), 32'd0);
        send_byte(8'h2E);
        check("ovf_set", 32'(bus_if.ovf), 32'd1);
        check("ovf_head_kept", 32'(bus_if.ev_data), 32'h016);
        bus_if.ev_ready = 1'b1;
        wait_drain("ovf_drain");
        check("ovf_sticky", 32'(bus_if.ovf), 32'd1);
        bus_if.ovf_clr = 1'b1;
        step();
        bus_if.ovf_clr = 1'b0;
        check("ovf_cleared", 32'(bus_if.ovf), 32'd0);

        // full FIFO with push and pop in the same cycle
        bus_if.ev_ready = 1'b0;
        exp_q.push_back(10'h016);
        exp_q.push_back(10'h01E);
        exp_q.push_back(10'h026);
        exp_q.push_back(10'h025);
        send_byte(8'h16);
        send_byte(8'h1E);
        send_byte(8'h26);
        send_byte(8'h25);
        exp_q.push_back(10'h02E);
        bus_if.scan_code  = 8'h2E;
        bus_if.scan_ready = 1'b1;
        exp_reads++;
        step();
        bus_if.scan_ready = 1'b0;
        bus_if.ev_ready   = 1'b1;
        step();
        bus_if.ev_ready = 1'b0;
        check("full_pushpop_ovf", 32'(bus_if.ovf), 32'd0);
        check("full_pushpop_head", 32'(bus_if.ev_data), 32'h01E);
        // still four held: another push drops, and set beats a same-cycle clear
        bus_if.scan_code  = 8'h36;
        bus_if.scan_ready = 1'b1;
        exp_reads++;
        step();
        bus_if.scan_ready = 1'b0;
        bus_if.ovf_clr    = 1'b1;
        step();
        bus_if.ovf_clr = 1'b0;
        check("ovf_set_wins", 32'(bus_if.ovf), 32'd1);
        bus_if.ev_ready = 1'b1;
        wait_drain("pushpop_drain");
        bus_if.ovf_clr = 1'b1;
        step();
        bus_if.ovf_clr = 1'b0;

        // reset while in EXT_BRK with two events queued
        bus_if.ev_ready = 1'b0;
        send_byte(8'h1C);
        send_byte(8'h1B);
        send_byte(8'hE0);
        send_byte(8'hF0);
        check("pre_rst_valid", 32'(bus_if.ev_valid), 32'd1);
        check("pre_rst_head", 32'(bus_if.ev_data), 32'h01C);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(bus_if.ev_valid), 32'd0);
        check("async_rst_data", 32'(bus_if.ev_data), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        bus_if.ev_ready = 1'b1;
        exp_q.push_back(10'h01C);
        send_byte(8'h1C);
        wait_drain("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
